cpu_sim_sequencer: RTL

- Synthesizable replacement for the hard-coded stimulus in the CPU simulation top: drives the core's reset, RDY, IRQ and NMI from parameters and ends the run.
- Sits between the clock/reset source and the cpu/ram pair. Snoops AB, sync, WE and DO.
- Adds programmable wait states, timed interrupt injection, and three stop conditions: cycle limit, fetch from a halt address, or a write to a done port. Each stop condition has a reported cause.

---
 rtl/cpu_sim_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cpu_sim_sequencer.sv
// cpu_sim_sequencer: parameterised stimulus for the CPU simulation top.
// Releases the core from reset and drives wait states and timed IRQ/NMI.
// Ends the run on a cycle limit, a fetch from a halt address, or a write
// to a done port, and reports which of the three stopped it.
module cpu_sim_sequencer #(
    parameter int              AW          = 24,
    parameter int              CW          = 32,
    parameter int              CYCLES      = 1000,
    parameter int              RST_CYCLES  = 2,
    parameter int              WAIT_PERIOD = 0,
    parameter int              WAIT_LEN    = 1,
    parameter int              IRQ_AT      = 0,
    parameter int              IRQ_LEN     = 4,
    parameter int              NMI_AT      = 0,
    parameter int              NMI_LEN     = 1,
    parameter int              HALT_EN     = 0,
    parameter logic [AW-1:0]   HALT_ADDR   = '0,
    parameter int              DONE_EN     = 1,
    parameter logic [AW-1:0]   DONE_ADDR   = 24'hFFFFF0
) (
    input  logic          clk,
    input  logic          RST,
    input  logic [AW-1:0] AB,
    input  logic          sync,
    input  logic          WE,
    input  logic [7:0]    DO,
    output logic          cpu_rst,
    output logic          RDY,
    output logic          IRQ,
    output logic          NMI,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] instr_cnt,
    output logic          done,
    output logic [1:0]    done_cause,
    output logic [7:0]    done_code
);

    localparam int PW = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_CYC  = CW'(CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(WAIT_PERIOD - 1);
    localparam logic [PW-1:0] RDY_OFF   = PW'(WAIT_PERIOD - WAIT_LEN);
    localparam logic [CW:0]   IRQ_LO    = (CW+1)'(IRQ_AT);
    localparam logic [CW:0]   IRQ_HI    = (CW+1)'(IRQ_AT + IRQ_LEN);
    localparam logic [CW:0]   NMI_LO    = (CW+1)'(NMI_AT);
    localparam logic [CW:0]   NMI_HI    = (CW+1)'(NMI_AT + NMI_LEN);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

    state_t        state, n_state;
    logic [HW-1:0] hold_cnt, n_hold_cnt;
    logic [PW-1:0] phase, n_phase;
    logic          n_cpu_rst, n_rdy, n_irq, n_nmi, n_done;
    logic [CW-1:0] n_cycle_cnt, n_instr_cnt, cyc_inc;
    logic [1:0]    n_done_cause;
    logic [7:0]    n_done_code;
    logic          stop_w, stop_h, stop_l;

    // Interrupt windows are expressed against the cycle count the CPU will see
    function automatic logic irq_on(input logic [CW-1:0] c);
        return (IRQ_AT != 0) && ({1'b0, c} >= IRQ_LO) && ({1'b0, c} < IRQ_HI);
    endfunction

    function automatic logic nmi_on(input logic [CW-1:0] c);
        return (NMI_AT != 0) && ({1'b0, c} >= NMI_LO) && ({1'b0, c} < NMI_HI);
    endfunction

    // Wait states occupy the tail of each period so phase 0 is always ready
    function automatic logic rdy_of(input logic [PW-1:0] p);
        return (WAIT_PERIOD == 0) ? 1'b1 : (p < RDY_OFF);
    endfunction

    assign cyc_inc = cycle_cnt + CW'(1);
    assign stop_w  = (DONE_EN != 0) && WE && RDY && (AB == DONE_ADDR);
    assign stop_h  = (HALT_EN != 0) && sync && RDY && (AB == HALT_ADDR);
    assign stop_l  = (cycle_cnt == LAST_CYC);

    // Next-state and next-output logic; every output is computed one cycle ahead
    always_comb begin
        n_state      = state;
        n_hold_cnt   = hold_cnt;
        n_phase      = phase;
        n_cpu_rst    = cpu_rst;
        n_rdy        = RDY;
        n_irq        = IRQ;
        n_nmi        = NMI;
        n_cycle_cnt  = cycle_cnt;
        n_instr_cnt  = instr_cnt;
        n_done       = done;
        n_done_cause = done_cause;
        n_done_code  = done_code;
        if (RST) begin
            n_state      = S_HOLD;
            n_hold_cnt   = '0;
            n_phase      = '0;
            n_cpu_rst    = 1'b1;
            n_rdy        = 1'b1;
            n_irq        = 1'b0;
            n_nmi        = 1'b0;
            n_cycle_cnt  = '0;
            n_instr_cnt  = '0;
            n_done       = 1'b0;
            n_done_cause = 2'd0;
            n_done_code  = 8'h00;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        n_state     = S_RUN;
                        n_cpu_rst   = 1'b0;
                        n_phase     = '0;
                        n_cycle_cnt = '0;
                        n_instr_cnt = '0;
                        n_rdy       = rdy_of('0);
                        n_irq       = irq_on('0);
                        n_nmi       = nmi_on('0);
                    end else begin
                        n_hold_cnt = hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    n_cycle_cnt = cyc_inc;
                    if (sync && RDY) n_instr_cnt = instr_cnt + CW'(1);
                    if (stop_w || stop_h || stop_l) begin
                        n_state = S_DONE;
                        n_done  = 1'b1;
                        n_rdy   = 1'b0;
                        n_irq   = 1'b0;
                        n_nmi   = 1'b0;
                        if (stop_w) begin
                            n_done_cause = 2'd3;
                            n_done_code  = DO;
                        end else if (stop_h) begin
                            n_done_cause = 2'd2;
                        end else begin
                            n_done_cause = 2'd1;
                        end
                    end else begin
                        n_phase = ((WAIT_PERIOD == 0) || (phase == PH_LAST)) ? '0 : phase + PW'(1);
                        n_rdy   = rdy_of(n_phase);
                        n_irq   = irq_on(cyc_inc);
                        n_nmi   = nmi_on(cyc_inc);
                    end
                end
                S_DONE: begin
                end
                default: n_state = S_HOLD;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        state      <= n_state;
        hold_cnt   <= n_hold_cnt;
        phase      <= n_phase;
        cpu_rst    <= n_cpu_rst;
        RDY        <= n_rdy;
        IRQ        <= n_irq;
        NMI        <= n_nmi;
        cycle_cnt  <= n_cycle_cnt;
        instr_cnt  <= n_instr_cnt;
        done       <= n_done;
        done_cause <= n_done_cause;
        done_code  <= n_done_code;
    end

endmodule
